// File: rtl/par_frame_pkg.sv
// Shared types for the parity frame generator.
// FSM state encoding and parity mode constants.
package par_frame_pkg;

  typedef enum logic {
    DATA = 1'b0,
    PAR  = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/par_out_stage.sv
// Single-entry valid/ready holding register (bit + last).
// Ports: clk, reset_n, load/d_bit/d_last in, out_ready in; load_ok, out_valid/out_bit/out_last out.
module par_out_stage (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic d_bit,
  input  logic d_last,
  input  logic out_ready,
  output logic load_ok,
  output logic out_valid,
  output logic out_bit,
  output logic out_last
);

  logic [1:0] q;

  assign load_ok  = !out_valid || out_ready;
  assign out_bit  = q[1];
  assign out_last = q[0];

  // load is only raised by the producer while load_ok holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      q         <= 2'b00;
    end else if (load) begin
      out_valid <= 1'b1;
      q         <= {d_bit, d_last};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/par_frame_gen.sv
// Serial framer: passes FRAME_LEN data bits then appends a parity bit.
// Ports: clk, reset_n, flush, mode, in_valid/in_bit/in_ready, out_valid/out_bit/out_last/out_ready,
// frame_busy; err_inj only when PAR_ERR_INJ_EN is defined (inverts next parity bit).
module par_frame_gen
  import par_frame_pkg::*;
#(
  parameter int   FRAME_LEN   = 8,
  parameter logic ODD_DEFAULT = PAR_EVEN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic mode,
`ifdef PAR_ERR_INJ_EN
  input  logic err_inj,
`endif
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  input  logic out_ready,
  output logic frame_busy
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          mode_lat;
  logic          load_ok;
  logic          take;
  logic          ins;
  logic          inv;
  logic          ld_bit;

  assign in_ready   = (state == DATA) && load_ok && !flush;
  assign take       = in_valid && in_ready;
  assign ins        = (state == PAR) && load_ok && !flush;
  assign frame_busy = (cnt != '0) || (state == PAR);
  assign ld_bit     = take ? in_bit : (acc ^ mode_lat ^ inv);

`ifdef PAR_ERR_INJ_EN
  logic err_q;

  // a same-cycle request also hits the parity bit being inserted
  assign inv = err_q | err_inj;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (flush || ins)
      err_q <= 1'b0;
    else if (err_inj)
      err_q <= 1'b1;
  end
`else
  assign inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DATA;
      cnt      <= '0;
      acc      <= 1'b0;
      mode_lat <= ODD_DEFAULT;
    end else if (flush) begin
      state <= DATA;
      cnt   <= '0;
      acc   <= 1'b0;
    end else if (take) begin
      acc <= acc ^ in_bit;
      if (cnt == '0)
        mode_lat <= mode;
      if (cnt == LAST) begin
        state <= PAR;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (ins) begin
      acc   <= 1'b0;
      state <= DATA;
    end
  end

  par_out_stage u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (take || ins),
    .d_bit     (ld_bit),
    .d_last    (!take),
    .out_ready (out_ready),
    .load_ok   (load_ok),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_par_frame_gen.sv
// Randomized + directed bench for par_frame_gen.
// Reference model: queue of the frame's bits, parity from a ones count.
module tb_par_frame_gen;

  localparam int FL = 8;
`ifdef PAR_ERR_INJ_EN
  localparam logic INJ_EN = 1'b1;
`else
  localparam logic INJ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, flush, mode, err_inj;
  logic in_valid, in_bit, in_ready;
  logic out_valid, out_bit, out_last, out_ready;
  logic frame_busy;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int last_par = -1;

  logic m_ov, m_ob, m_ol, m_full, m_mode, m_err;
  logic fq[$];

  always #5 clk = ~clk;

  par_frame_gen #(.FRAME_LEN(FL), .ODD_DEFAULT(1'b0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .mode       (mode),
`ifdef PAR_ERR_INJ_EN
    .err_inj    (err_inj),
`endif
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_busy (frame_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_full = 1'b0;
    m_ov   = 1'b0;
    m_ob   = 1'b0;
    m_ol   = 1'b0;
    m_mode = 1'b0;
    m_err  = 1'b0;
  endtask

  // one cycle: drive at negedge, compare, advance model to next posedge
  task automatic step(input logic iv, input logic ib, input logic ordy,
                      input logic md, input logic fl, input logic ei,
                      output logic acc);
    logic lok, rdy, inj, par;
    int ones;
    @(negedge clk);
    in_valid = iv; in_bit = ib; out_ready = ordy;
    mode = md; flush = fl; err_inj = ei;
    #1;
    lok = !m_ov || ordy;
    rdy = !m_full && lok && !fl;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    chk("frame_busy", frame_busy, fq.size() != 0);
    if (m_ov) begin
      chk("out_bit", out_bit, m_ob);
      chk("out_last", out_last, m_ol);
    end
    if (out_valid && ordy) begin
      beats++;
      if (out_last) last_par = int'(out_bit);
    end
    acc = iv && rdy;
    inj = (m_err | err_inj) & INJ_EN;
    if (fl) begin
      fq.delete();
      m_full = 1'b0;
      m_err  = 1'b0;
      if (ordy) m_ov = 1'b0;
    end else if (acc) begin
      if (fq.size() == 0) m_mode = md;
      fq.push_back(ib);
      if (fq.size() == FL) m_full = 1'b1;
      m_ov = 1'b1; m_ob = ib; m_ol = 1'b0;
      if (ei) m_err = 1'b1;
    end else if (m_full && lok) begin
      ones = 0;
      foreach (fq[k]) ones += int'(fq[k]);
      par = ones[0] ^ m_mode ^ inj;
      m_ov = 1'b1; m_ob = par; m_ol = 1'b1;
      fq.delete();
      m_full = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (ordy) m_ov = 1'b0;
      if (ei) m_err = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
  endtask

  // b[i] is the i-th serial bit; inj_at < 0 means no error pulse
  task automatic send(input logic [FL-1:0] b, input logic md0,
                      input logic mdr, input int inj_at);
    logic a;
    for (int i = 0; i < FL; i++)
      step(1'b1, b[i], 1'b1, (i == 0) ? md0 : mdr, 1'b0,
           (i == inj_at), a);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0; flush = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", frame_busy, 0);
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic a;
    int cyc, idx;
    logic [FL-1:0] sb;

    reset_n = 1'b0; flush = 1'b0; mode = 1'b0; err_inj = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", frame_busy, 0);
    chk("init_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // bits 1,0,1,1,0,0,0,0 even parity
    beats = 0; last_par = -1;
    send(8'b0000_1101, 1'b0, 1'b0, -1);
    idle(3);
    chk("f034_beats", beats, 9);
    chk("f034_par", last_par, 1);

    // odd parity, mode flipped mid-frame is ignored
    beats = 0; last_par = -1;
    send(8'b0000_1101, 1'b1, 1'b0, -1);
    idle(3);
    chk("f035_beats", beats, 9);
    chk("f035_par", last_par, 0);

    // downstream stall on beat 4
    beats = 0; last_par = -1;
    sb = 8'b0110_1101;
    idx = 0; cyc = 0;
    while (idx < FL && cyc < 100) begin
      step(1'b1, sb[idx], !(cyc >= 4 && cyc < 7), 1'b0, 1'b0, 1'b0, a);
      if (a) idx++;
      cyc++;
    end
    chk("f036_all_taken", idx, FL);
    idle(3);
    chk("f036_beats", beats, 9);
    chk("f036_par", last_par, 1);

    // flush after 4 bits
    send(8'b0000_0000, 1'b0, 1'b0, -1);
    idle(3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
    @(posedge clk);
    #1 chk("f037_busy", frame_busy, 0);
    beats = 0; last_par = -1;
    send(8'b0000_0000, 1'b0, 1'b0, -1);
    idle(3);
    chk("f037_beats", beats, 9);
    chk("f037_par", last_par, 0);

    // reset mid-frame, parity from fresh bits only
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
    mid_reset();
    beats = 0; last_par = -1;
    send(8'b0000_0001, 1'b0, 1'b0, -1);
    idle(3);
    chk("f038_beats", beats, 9);
    chk("f038_par", last_par, 1);

`ifdef PAR_ERR_INJ_EN
    last_par = -1;
    send(8'hFF, 1'b0, 1'b0, 2);
    idle(3);
    chk("f039_par1", last_par, 1);
    last_par = -1;
    send(8'hFF, 1'b0, 1'b0, -1);
    idle(3);
    chk("f039_par2", last_par, 0);
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) mid_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 9) < 7, 1'($urandom),
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0, a);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
